// File: rtl/reg_access_pkg.sv
// Shared types and constants for the UART-side register access master.
package reg_access_pkg;

    // Frame-processing states of the access master.
    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StDoWrite,
        StReadReq,
        StReadWait,
        StTxWait
    } state_e;

    // Command byte bit selecting write (1) or read (0).
    localparam int unsigned CMD_WRITE_BIT = 7;

    // Byte returned to the host when a read never completes.
    localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

    // Width of the saturating dropped-byte counter.
    localparam int unsigned DROP_CNT_W = 8;

endpackage

// File: rtl/cycle_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count compare.
// Counting stops at the terminal value so a stalled caller never sees a wrap.
module cycle_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic             done_o
);

    logic [Width-1:0] count_q, count_d;

    assign done_o = (count_q == term_i);

    // Next count: clear beats load beats increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && !done_o) begin
            count_d = count_q + Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reg_access_master.sv
// Parses UART command frames and issues single-cycle register-file writes or
// reads; read results (or an error byte on timeout) go back to the UART
// transmitter. Every output is a flop, so each strobe appears one cycle after
// the state that decides it.
module reg_access_master
    import reg_access_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH          = 8,
    parameter int unsigned              REGISTER_FILE_DEPTH = 16,
    parameter int unsigned              BYTE_TIMEOUT        = 100000,
    parameter int unsigned              RD_TIMEOUT          = 16,
    parameter logic [DATA_WIDTH-1:0]    ERR_BYTE            = DATA_WIDTH'(DEFAULT_ERR_BYTE),
    localparam int unsigned             ADDR_W              = $clog2(REGISTER_FILE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [ADDR_W-1:0]     address,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  read_en,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_data_valid,
    output logic                  rd_timeout_err,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int unsigned TMR_MAX = (BYTE_TIMEOUT > RD_TIMEOUT) ? BYTE_TIMEOUT : RD_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] BYTE_TERM = TMR_W'(BYTE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RD_TERM   = TMR_W'(RD_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic                    tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [ADDR_W-1:0]       address_q, address_d;
    logic                    write_en_q, write_en_d;
    logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
    logic                    read_en_q, read_en_d;
    logic                    rd_timeout_err_q, rd_timeout_err_d;
    logic [DROP_CNT_W-1:0]   drop_count_q, drop_count_d;

    logic                    tmr_clear;
    logic                    tmr_load;
    logic [TMR_W-1:0]        tmr_load_val;
    logic                    tmr_en;
    logic [TMR_W-1:0]        tmr_term;
    logic                    tmr_done;

    // One timer serves both waits; only one of them can be active at a time.
    assign tmr_en   = (state_q == StWaitData) || (state_q == StReadWait);
    assign tmr_term = (state_q == StReadWait) ? RD_TERM : BYTE_TERM;

    cycle_timer #(
        .Width (TMR_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .term_i     (tmr_term),
        .done_o     (tmr_done)
    );

    // Next-state and next-output decode for the frame FSM.
    always_comb begin
        state_d          = state_q;
        tx_start_d       = 1'b0;
        tx_data_d        = tx_data_q;
        address_d        = address_q;
        write_en_d       = 1'b0;
        write_data_d     = write_data_q;
        read_en_d        = 1'b0;
        rd_timeout_err_d = rd_timeout_err_q;
        drop_count_d     = drop_count_q;
        tmr_load         = 1'b0;
        tmr_load_val     = '0;

        case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    address_d = rx_data[ADDR_W-1:0];
                    if (rx_data[CMD_WRITE_BIT]) begin
                        state_d  = StWaitData;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = StReadReq;
                    end
                end
            end
            StWaitData: begin
                // A data byte arriving on the expiry cycle still wins.
                if (rx_valid) begin
                    write_data_d = rx_data;
                    state_d      = StDoWrite;
                end else if (tmr_done) begin
                    state_d = StIdle;
                end
            end
            StDoWrite: begin
                write_en_d = 1'b1;
                state_d    = StIdle;
            end
            StReadReq: begin
                read_en_d    = 1'b1;
                state_d      = StReadWait;
                // Preload 1 so the TX_WAIT hand-off cycle is part of the read
                // budget: the error tx_start lands RD_TIMEOUT cycles after entry.
                tmr_load     = 1'b1;
                tmr_load_val = TMR_W'(1);
            end
            StReadWait: begin
                if (read_data_valid) begin
                    tx_data_d = read_data;
                    state_d   = StTxWait;
                end else if (tmr_done) begin
                    tx_data_d        = ERR_BYTE;
                    rd_timeout_err_d = 1'b1;
                    state_d          = StTxWait;
                end
            end
            StTxWait: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Only IDLE and WAIT_DATA consume bytes; anything else is dropped.
        if (rx_valid && (state_q != StIdle) && (state_q != StWaitData) &&
            (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_CNT_W'(1);
        end

        tmr_clear = (state_d == StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            tx_start_q       <= 1'b0;
            tx_data_q        <= '0;
            address_q        <= '0;
            write_en_q       <= 1'b0;
            write_data_q     <= '0;
            read_en_q        <= 1'b0;
            rd_timeout_err_q <= 1'b0;
            drop_count_q     <= '0;
        end else begin
            state_q          <= state_d;
            tx_start_q       <= tx_start_d;
            tx_data_q        <= tx_data_d;
            address_q        <= address_d;
            write_en_q       <= write_en_d;
            write_data_q     <= write_data_d;
            read_en_q        <= read_en_d;
            rd_timeout_err_q <= rd_timeout_err_d;
            drop_count_q     <= drop_count_d;
        end
    end

    assign tx_start       = tx_start_q;
    assign tx_data        = tx_data_q;
    assign address        = address_q;
    assign write_en       = write_en_q;
    assign write_data     = write_data_q;
    assign read_en        = read_en_q;
    assign rd_timeout_err = rd_timeout_err_q;
    assign drop_count     = drop_count_q;

endmodule
